// File: rtl/ir_pipeline_fetch_pkg.sv
// Shared opcode constants and fetch FSM state type.
// The pipeline controller's decode imports this package too.
package ir_pipeline_fetch_pkg;

    // Opcode nibble IR[3:0]
    localparam logic [3:0] OP_NOP   = 4'b1010;
    localparam logic [3:0] OP_STOP  = 4'b0001;
    localparam logic [3:0] OP_LOAD  = 4'b0010;
    localparam logic [3:0] OP_STORE = 4'b0011;
    localparam logic [3:0] OP_BZ    = 4'b0100;
    localparam logic [3:0] OP_BNZ   = 4'b0101;
    localparam logic [3:0] OP_BPZ   = 4'b0110;
    localparam logic [3:0] OP_ORI   = 4'b0111;

    localparam logic [7:0] NOP_WORD = {4'b0000, OP_NOP};

    typedef enum logic [1:0] {
        FETCH_RUN,
        FETCH_DRAIN,
        FETCH_HALT
    } fetch_state_t;

    function automatic logic has_opcode(input logic [7:0] word, input logic [3:0] op);
        return word[3:0] == op;
    endfunction

endpackage

// File: rtl/ir_stage_reg.sv
// One instruction-register stage: sync reset and NOP injection both load the bubble
// word; inject_nop wins over load.
module ir_stage_reg
    import ir_pipeline_fetch_pkg::*;
#(
    parameter logic [7:0] BUBBLE = NOP_WORD
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       load,
    input  logic       inject_nop,
    input  logic [7:0] d,
    output logic [7:0] q
);

    // NOTE: state is written with <= so every stage samples its neighbour's pre-edge value.
    always_ff @(posedge clock) begin
        if (reset || inject_nop) begin
            q <= BUBBLE;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/ir_pipeline_fetch.sv
// Fetch stage: PC, RUN/DRAIN/HALT sequencing, branch flush window and the
// IR1..IR4 shift chain with bubble insertion.
module ir_pipeline_fetch
    import ir_pipeline_fetch_pkg::*;
#(
    parameter int                  PC_WIDTH     = 8,
    parameter logic [PC_WIDTH-1:0] RESET_PC     = '0,
    parameter logic [7:0]          NOP_WORD     = ir_pipeline_fetch_pkg::NOP_WORD,
    parameter logic [3:0]          STOP_OP      = OP_STOP,
    parameter int                  FLUSH_CYCLES = 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [7:0]          InstrIn,
    input  logic                InstrValid,
    input  logic                StallIn,
    input  logic                BranchTaken,
    input  logic [PC_WIDTH-1:0] BranchTarget,
    output logic [PC_WIDTH-1:0] PCOut,
    output logic                FetchReq,
    output logic [7:0]          IR1Out,
    output logic [7:0]          IR2Out,
    output logic [7:0]          IR3Out,
    output logic [7:0]          IR4Out,
    output logic                branching,
    output logic                Halted
);

    localparam int CNT_W = (FLUSH_CYCLES < 1) ? 1 : $clog2(FLUSH_CYCLES + 1);

    fetch_state_t        state, state_next;
    logic [PC_WIDTH-1:0] pc;
    logic [CNT_W-1:0]    flush_cnt;

    logic active, do_branch, do_stall, do_shift, accept;
    logic ir1_load, ir1_nop, ir2_load, ir2_nop, ir3_load, ir3_nop, ir4_load;

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= FETCH_RUN;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: a taken branch in DRAIN kills the younger stop; the stop
    // sitting in IR3 during DRAIN is the one about to retire into IR4.
    always_comb begin
        state_next = state;
        unique case (state)
            FETCH_RUN:   if (accept && has_opcode(InstrIn, STOP_OP)) state_next = FETCH_DRAIN;
            FETCH_DRAIN: begin
                if (BranchTaken)                        state_next = FETCH_RUN;
                else if (has_opcode(IR3Out, STOP_OP))   state_next = FETCH_HALT;
            end
            FETCH_HALT:  state_next = FETCH_HALT;
            default:     state_next = FETCH_RUN;
        endcase
    end

    // Output / stage-control decode
    // NOTE: every signal gets a default before the branches so no latch is inferred.
    always_comb begin
        active    = (state != FETCH_HALT);
        do_branch = active && BranchTaken;
        do_stall  = active && !BranchTaken && StallIn;
        do_shift  = active && !BranchTaken && !StallIn;
        accept    = do_shift && (state == FETCH_RUN) && InstrValid;
        FetchReq  = (state == FETCH_RUN) && !StallIn;
        Halted    = (state == FETCH_HALT);

        ir1_load  = accept;
        ir1_nop   = do_branch || (do_shift && !accept);
        ir2_load  = do_shift;
        ir2_nop   = do_branch;
        ir3_load  = do_shift;
        ir3_nop   = do_branch || do_stall;
        ir4_load  = active;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc <= RESET_PC;
        end else if (do_branch) begin
            pc <= BranchTarget;
        end else if (accept) begin
            pc <= pc + PC_WIDTH'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            flush_cnt <= '0;
        end else if (do_branch) begin
            flush_cnt <= CNT_W'(FLUSH_CYCLES);
        end else if (active && flush_cnt != '0) begin
            flush_cnt <= flush_cnt - CNT_W'(1);
        end
    end

    assign PCOut     = pc;
    assign branching = (flush_cnt != '0);

    ir_stage_reg #(.BUBBLE(NOP_WORD)) u_ir1 (
        .clock(clock), .reset(reset), .load(ir1_load), .inject_nop(ir1_nop),
        .d(InstrIn), .q(IR1Out));
    ir_stage_reg #(.BUBBLE(NOP_WORD)) u_ir2 (
        .clock(clock), .reset(reset), .load(ir2_load), .inject_nop(ir2_nop),
        .d(IR1Out), .q(IR2Out));
    ir_stage_reg #(.BUBBLE(NOP_WORD)) u_ir3 (
        .clock(clock), .reset(reset), .load(ir3_load), .inject_nop(ir3_nop),
        .d(IR2Out), .q(IR3Out));
    ir_stage_reg #(.BUBBLE(NOP_WORD)) u_ir4 (
        .clock(clock), .reset(reset), .load(ir4_load), .inject_nop(1'b0),
        .d(IR3Out), .q(IR4Out));

endmodule

// File: tb/tb_ir_pipeline_fetch.sv
// Scoreboard bench: the stimulus process queues hand-computed post-edge snapshots,
// the monitor pops and compares them on the following falling edge.
module tb_ir_pipeline_fetch;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] InstrIn = '0;
    logic       InstrValid = 1'b0;
    logic       StallIn = 1'b0;
    logic       BranchTaken = 1'b0;
    logic [7:0] BranchTarget = '0;
    logic [7:0] PCOut;
    logic       FetchReq;
    logic [7:0] IR1Out, IR2Out, IR3Out, IR4Out;
    logic       branching;
    logic       Halted;

    ir_pipeline_fetch dut (
        .clock(clock), .reset(reset),
        .InstrIn(InstrIn), .InstrValid(InstrValid), .StallIn(StallIn),
        .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
        .PCOut(PCOut), .FetchReq(FetchReq),
        .IR1Out(IR1Out), .IR2Out(IR2Out), .IR3Out(IR3Out), .IR4Out(IR4Out),
        .branching(branching), .Halted(Halted)
    );

    always #5 clock = ~clock;

    typedef struct {
        string      nm;
        logic [7:0] pc, ir1, ir2, ir3, ir4;
        logic       freq, brn, halt;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    function automatic exp_t mk(input string nm, input logic [7:0] pc, input logic [7:0] ir1,
                                input logic [7:0] ir2, input logic [7:0] ir3, input logic [7:0] ir4,
                                input logic freq, input logic brn, input logic halt);
        exp_t e;
        e.nm = nm; e.pc = pc; e.ir1 = ir1; e.ir2 = ir2; e.ir3 = ir3; e.ir4 = ir4;
        e.freq = freq; e.brn = brn; e.halt = halt;
        return e;
    endfunction

    task automatic check(input string nm, input logic [7:0] actual, input logic [7:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("FAIL %s: got %02h expected %02h", nm, actual, expected);
    endtask

    // Monitor: compare every queued snapshot on the falling edge after its clock edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            while (q.size() != 0) begin
                e = q.pop_front();
                check({e.nm, ".pc"},   PCOut,            e.pc);
                check({e.nm, ".ir1"},  IR1Out,           e.ir1);
                check({e.nm, ".ir2"},  IR2Out,           e.ir2);
                check({e.nm, ".ir3"},  IR3Out,           e.ir3);
                check({e.nm, ".ir4"},  IR4Out,           e.ir4);
                check({e.nm, ".freq"}, {7'd0, FetchReq}, {7'd0, e.freq});
                check({e.nm, ".brn"},  {7'd0, branching}, {7'd0, e.brn});
                check({e.nm, ".halt"}, {7'd0, Halted},   {7'd0, e.halt});
            end
        end
    end

    task automatic step(input logic rst, input logic [7:0] instr, input logic v, input logic s,
                        input logic b, input logic [7:0] tgt, input exp_t e);
        @(negedge clock);
        #1;
        reset = rst; InstrIn = instr; InstrValid = v; StallIn = s;
        BranchTaken = b; BranchTarget = tgt;
        @(posedge clock);
        #1;
        q.push_back(e);
    endtask

    initial begin
        //      rst instr  v  s  b  tgt            name       pc     ir1    ir2    ir3    ir4   fq br ht
        step(1, 8'h00, 0, 0, 0, 8'h00, mk("reset",  8'h00, 8'h0A, 8'h0A, 8'h0A, 8'h0A, 1, 0, 0));
        step(0, 8'h12, 1, 0, 0, 8'h00, mk("fetch1", 8'h01, 8'h12, 8'h0A, 8'h0A, 8'h0A, 1, 0, 0));
        step(0, 8'h22, 1, 0, 0, 8'h00, mk("fetch2", 8'h02, 8'h22, 8'h12, 8'h0A, 8'h0A, 1, 0, 0));
        step(0, 8'h33, 1, 0, 0, 8'h00, mk("fetch3", 8'h03, 8'h33, 8'h22, 8'h12, 8'h0A, 1, 0, 0));
        step(0, 8'h44, 1, 0, 0, 8'h00, mk("fetch4", 8'h04, 8'h44, 8'h33, 8'h22, 8'h12, 1, 0, 0));
        step(0, 8'hEE, 0, 0, 0, 8'h00, mk("bubble", 8'h04, 8'h0A, 8'h44, 8'h33, 8'h22, 1, 0, 0));
        step(0, 8'h37, 1, 0, 0, 8'h00, mk("fetch5", 8'h05, 8'h37, 8'h0A, 8'h44, 8'h33, 1, 0, 0));
        step(0, 8'h24, 1, 0, 0, 8'h00, mk("fetch6", 8'h06, 8'h24, 8'h37, 8'h0A, 8'h44, 1, 0, 0));
        step(0, 8'h56, 1, 0, 0, 8'h00, mk("fetch7", 8'h07, 8'h56, 8'h24, 8'h37, 8'h0A, 1, 0, 0));
        step(0, 8'h66, 1, 1, 0, 8'h00, mk("stall",  8'h07, 8'h56, 8'h24, 8'h0A, 8'h37, 0, 0, 0));
        step(0, 8'h66, 1, 0, 0, 8'h00, mk("resume", 8'h08, 8'h66, 8'h56, 8'h24, 8'h0A, 1, 0, 0));
        step(0, 8'h77, 1, 1, 1, 8'h40, mk("branch", 8'h40, 8'h0A, 8'h0A, 8'h0A, 8'h24, 0, 1, 0));
        step(0, 8'h00, 0, 0, 0, 8'h00, mk("flush1", 8'h40, 8'h0A, 8'h0A, 8'h0A, 8'h0A, 1, 1, 0));
        step(0, 8'h00, 0, 0, 0, 8'h00, mk("flush2", 8'h40, 8'h0A, 8'h0A, 8'h0A, 8'h0A, 1, 0, 0));
        step(0, 8'h00, 0, 0, 1, 8'hFF, mk("br_ff",  8'hFF, 8'h0A, 8'h0A, 8'h0A, 8'h0A, 1, 1, 0));
        step(0, 8'h23, 1, 0, 0, 8'h00, mk("wrap",   8'h00, 8'h23, 8'h0A, 8'h0A, 8'h0A, 1, 1, 0));
        step(0, 8'h01, 1, 0, 0, 8'h00, mk("stop1",  8'h01, 8'h01, 8'h23, 8'h0A, 8'h0A, 0, 0, 0));
        step(0, 8'h99, 1, 0, 0, 8'h00, mk("drain1", 8'h01, 8'h0A, 8'h01, 8'h23, 8'h0A, 0, 0, 0));
        step(0, 8'h00, 0, 0, 1, 8'h80, mk("squash", 8'h80, 8'h0A, 8'h0A, 8'h0A, 8'h23, 1, 1, 0));
        step(0, 8'h01, 1, 0, 0, 8'h00, mk("stop2",  8'h81, 8'h01, 8'h0A, 8'h0A, 8'h0A, 0, 1, 0));
        step(0, 8'h00, 0, 0, 0, 8'h00, mk("drainA", 8'h81, 8'h0A, 8'h01, 8'h0A, 8'h0A, 0, 0, 0));
        step(0, 8'h00, 0, 0, 0, 8'h00, mk("drainB", 8'h81, 8'h0A, 8'h0A, 8'h01, 8'h0A, 0, 0, 0));
        step(0, 8'h00, 0, 0, 0, 8'h00, mk("halt",   8'h81, 8'h0A, 8'h0A, 8'h0A, 8'h01, 0, 0, 1));
        step(0, 8'h55, 1, 1, 1, 8'h10, mk("frozen", 8'h81, 8'h0A, 8'h0A, 8'h0A, 8'h01, 0, 0, 1));
        step(1, 8'h00, 0, 0, 0, 8'h00, mk("rst2",   8'h00, 8'h0A, 8'h0A, 8'h0A, 8'h0A, 1, 0, 0));

        // Give the monitor a bounded window to drain the scoreboard.
        reset = 1'b0; InstrValid = 1'b0; BranchTaken = 1'b0; StallIn = 1'b0;
        for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clock);
        #1;
        n_checks++;
        if (q.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain: %0d entries left, required 0", q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
